fetch_controller: RTL
=====================

Name: fetch_controller

Overview:
- Sequences the fetch stage against a variable-latency instruction memory.
- Owns the next-PC register and issues one outstanding request at a time.
- Registers the returned instruction into the F-stage outputs with a one-entry skid buffer for stalls.
- Redirects to branch/jump targets, discarding any in-flight stale fetch.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC fetched first after reset
NOP_INSTR, 32'h0000_0013, value driven on Instr_F when Valid_F=0 (addi x0,x0,0)

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous, active-low reset
Stall_F  input  1  hazard unit holds F-stage outputs
Redirect  input  1  taken branch/jump from execute; priority over Stall_F
Redirect_PC  input  32  redirect target; bits [1:0] forced to 0
IMem_Req  output  1  request valid; held with stable IMem_Addr until IMem_Ack
IMem_Addr  output  32  word-aligned fetch address
IMem_Ack  input  1  completes request this cycle; IMem_RData valid same cycle
IMem_RData  input  32  instruction word
Instr_F  output  32  fetched instruction
PC_F  output  32  address of Instr_F
PC_Plus_4_F  output  32  PC_F + 4, modulo 2^32
Valid_F  output  1  Instr_F/PC_F hold a real instruction

Behaviour:
- Reset (RST=0, async): state=WAIT, Fetch_PC=RESET_VECTOR, Valid_F=0, Instr_F=NOP_INSTR, PC_F=RESET_VECTOR, skid empty. IMem_Req=0 while RST=0.
- IMem_Req=1 in WAIT and DROP; 0 in HOLD. IMem_Addr=Fetch_PC in WAIT, Drop_PC in DROP.
- A transfer completes on a rising edge where IMem_Req=1 and IMem_Ack=1. Zero-wait ack is legal: req in cycle N, ack in N, Valid_F=1 in N+1.
- WAIT, ack, output free (Valid_F=0 or Stall_F=0):
  - Instr_F<=RData, PC_F<=Fetch_PC, Valid_F<=1, Fetch_PC+=4.
  - Stay in WAIT; the next request issues in the following cycle. Sustained throughput is 1 instr/cycle with zero-wait memory.
- WAIT, ack, Stall_F=1 and Valid_F=1: capture RData/Fetch_PC into skid, Fetch_PC+=4, go to HOLD.
- WAIT, no ack, output free: Valid_F<=0, Instr_F<=NOP_INSTR (bubble).
- HOLD: outputs frozen while Stall_F=1. When Stall_F=0, skid→outputs, Valid_F=1, skid emptied, go to WAIT.
- Stall_F=1 with Valid_F=0: outputs do not hold; the bubble is overwritten.
- Redirect=1 (any state, overrides Stall_F) on a rising edge:
  - Valid_F<=0, Instr_F<=NOP_INSTR, skid emptied.
  - Fetch_PC<={Redirect_PC[31:2],2'b00}.
  - WAIT without ack → DROP, with Drop_PC=old Fetch_PC.
  - WAIT with ack → RData discarded, stay in WAIT.
  - HOLD → WAIT.
  - DROP → DROP; Drop_PC unchanged, Fetch_PC updated to newest target.
- DROP: Req held on Drop_PC. On ack, data discarded, go to WAIT; the request for Fetch_PC issues the next cycle. Valid_F stays 0 throughout DROP.
- PC wrap: 32'hFFFF_FFFC+4=32'h0000_0000; PC_Plus_4_F wraps the same way.
- Reset asserted mid-transfer: abandons the request immediately. Memory must tolerate Req dropping without ack.
- Invariant: at most one request outstanding; Addr/Req never change while Req=1 and Ack=0.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined, adds outputs Fetch_Count[31:0] and Wait_Count[31:0], both reset to 0, wrapping at 2^32:
  - Fetch_Count: +1 per completed non-discarded transfer.
  - Wait_Count: +1 per cycle with IMem_Req=1 and IMem_Ack=0.
- When undefined, neither port nor counter logic exists.
- Core behaviour is identical either way.

Test Plan:
- Zero-wait ack tied 1 after reset, RESET_VECTOR=0: PC_F = 0,4,8,C on consecutive cycles from cycle 1 after release; Valid_F=1 continuously; Instr_F matches memory word at PC_F[31:2].
- Ack after 2 wait cycles per request: Valid_F pattern 0,0,1 repeating; IMem_Addr stable while Req=1 and Ack=0; PC_F steps by 4.
- Stall_F=1 for 3 cycles while Valid_F=1 and an ack arrives: PC_F/Instr_F frozen; state=HOLD, Req=0. On release, next PC_F = old+4 with no lost or duplicated instruction.
- Redirect to 32'h0000_0102 with request to 0x10 pending:
  - IMem_Addr stays 0x10 until ack, and that data never appears on Instr_F.
  - Then IMem_Addr=0x100, and Valid_F rises with PC_F=0x100.
- Redirect and Stall_F=1 in the same cycle: redirect wins; Valid_F=0 next cycle; fetch resumes at target.
- Redirect to 32'hFFFF_FFFC with zero-wait memory: PC_F=FFFF_FFFC then 0000_0000; PC_Plus_4_F=0000_0000 then 0000_0004. Assert RST mid-request: IMem_Req=0 and Valid_F=0 immediately.

Source files
------------

// File: rtl/fetch_controller.sv
// Fetch-stage sequencer: one outstanding request to a variable-latency IMEM, one-entry skid for stalls.
// Optional performance counters (Fetch_Count, Wait_Count) are built when FETCH_PERF_CNT_EN is defined.
module fetch_controller #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Stall_F,
    input  logic        Redirect,
    input  logic [31:0] Redirect_PC,
    output logic        IMem_Req,
    output logic [31:0] IMem_Addr,
    input  logic        IMem_Ack,
    input  logic [31:0] IMem_RData,
    output logic [31:0] Instr_F,
    output logic [31:0] PC_F,
    output logic [31:0] PC_Plus_4_F,
    output logic        Valid_F
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] Fetch_Count,
    output logic [31:0] Wait_Count
`endif
);

    localparam logic [1:0] S_WAIT = 2'd0;
    localparam logic [1:0] S_HOLD = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] drop_pc_q, drop_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        xfer;
    logic        out_free;

    // Request is gated by reset so an in-flight fetch is abandoned the moment reset asserts.
    assign IMem_Req    = RST && (state_q != S_HOLD);
    assign IMem_Addr   = (state_q == S_DROP) ? drop_pc_q : fetch_pc_q;
    assign xfer        = IMem_Req && IMem_Ack;
    assign out_free    = !valid_q || !Stall_F;

    assign Instr_F     = instr_q;
    assign PC_F        = pc_q;
    assign PC_Plus_4_F = pc_q + 32'd4;
    assign Valid_F     = valid_q;

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        drop_pc_d    = drop_pc_q;
        instr_d      = instr_q;
        pc_d         = pc_q;
        valid_d      = valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        if (Redirect) begin
            valid_d    = 1'b0;
            instr_d    = NOP_INSTR;
            fetch_pc_d = Redirect_PC & 32'hFFFF_FFFC;
            // A fresh request still pending becomes stale; it must finish before the new target issues.
            if (state_q == S_WAIT && !xfer) begin
                state_d   = S_DROP;
                drop_pc_d = fetch_pc_q;
            end else if (state_q == S_HOLD) begin
                state_d = S_WAIT;
            end
        end else begin
            case (state_q)
                S_WAIT: begin
                    if (xfer) begin
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        if (out_free) begin
                            instr_d = IMem_RData;
                            pc_d    = fetch_pc_q;
                            valid_d = 1'b1;
                        end else begin
                            skid_instr_d = IMem_RData;
                            skid_pc_d    = fetch_pc_q;
                            state_d      = S_HOLD;
                        end
                    end else if (out_free) begin
                        valid_d = 1'b0;
                        instr_d = NOP_INSTR;
                    end
                end
                S_HOLD: begin
                    if (!Stall_F) begin
                        instr_d = skid_instr_q;
                        pc_d    = skid_pc_q;
                        valid_d = 1'b1;
                        state_d = S_WAIT;
                    end
                end
                S_DROP: begin
                    if (xfer) begin
                        state_d = S_WAIT;
                    end
                end
                default: state_d = S_WAIT;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= S_WAIT;
            fetch_pc_q <= RESET_VECTOR;
            drop_pc_q  <= RESET_VECTOR;
            instr_q    <= NOP_INSTR;
            pc_q       <= RESET_VECTOR;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            drop_pc_q  <= drop_pc_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
        end
    end

    // Skid contents are only meaningful in HOLD, so they need no reset.
    always_ff @(posedge CLK) begin
        skid_instr_q <= skid_instr_d;
        skid_pc_q    <= skid_pc_d;
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, wait_cnt_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            fetch_cnt_q <= 32'd0;
            wait_cnt_q  <= 32'd0;
        end else begin
            if (xfer && state_q == S_WAIT && !Redirect) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (IMem_Req && !IMem_Ack) begin
                wait_cnt_q <= wait_cnt_q + 32'd1;
            end
        end
    end

    assign Fetch_Count = fetch_cnt_q;
    assign Wait_Count  = wait_cnt_q;
`endif

endmodule
